// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller for the pipelined MIPS32 core with TLB.
// Holds Status, Cause and EPC. Prioritises dtlb > ov > itlb > unimpl > sys > int.
// Picks the EPC from the faulting pipeline stage, with branch-delay handling.
// Sequences take -> flush -> idle and drives selpc/cancel to the IF/ID logic.
//
// Ports:
//   clk_i, clr_i            clock (rising edge), asynchronous active-high reset
//   irq_i                   level interrupt requests (NIRQ lines)
//   exc_req_i               {dtlb, ov, itlb, unimpl, sys} raw exception requests
//   stall_id_i              ID stage stalled
//   isbr_d/m/w_i            instruction in ID/MEM/WB is a branch or jump
//   pc_f/d/e/m/w_i          PC of the instruction in IF/ID/EXE/MEM/WB
//   eret_i                  eret decoded in ID
//   wc0_i, c0_waddr_i, c0_wdata_i   mtc0 strobe, register number, data
//   c0_raddr_i, c0_rdata_o  mfc0 register number and combinational read data
//   sta_o, cause_o, epc_o   Status, Cause and EPC registers
//   selpc_o                 00 npc, 01 epc, 10 exception base
//   cancel_o                squash younger instructions
//   exc_taken_o             one-cycle pulse when an exception is taken
module cp0_exc_ctrl #(
  parameter int unsigned NIRQ      = 6,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic [NIRQ-1:0] irq_i,
  input  logic [4:0]      exc_req_i,
  input  logic            stall_id_i,
  input  logic            isbr_d_i,
  input  logic            isbr_m_i,
  input  logic            isbr_w_i,
  input  logic [XLEN-1:0] pc_f_i,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [XLEN-1:0] pc_e_i,
  input  logic [XLEN-1:0] pc_m_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic            eret_i,
  input  logic            wc0_i,
  input  logic [4:0]      c0_waddr_i,
  input  logic [4:0]      c0_raddr_i,
  input  logic [XLEN-1:0] c0_wdata_i,
  output logic [XLEN-1:0] c0_rdata_o,
  output logic [XLEN-1:0] sta_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] epc_o,
  output logic [1:0]      selpc_o,
  output logic            cancel_o,
  output logic            exc_taken_o
);

  localparam int unsigned CntW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StTake, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Status fields
  logic [5:0]        en_q, en_d;
  logic              exl_q, exl_d;
  logic [NIRQ-1:0]   im_q, im_d;
  // Cause fields
  logic [4:0]        code_q, code_d;
  logic              bd_q, bd_d;
  logic [NIRQ-1:0]   ip_q, ip_d;
  logic [XLEN-1:0]   epc_q, epc_d;

  // Only a subset of the mtc0 data bits lands in a register.
  logic unused_wdata;
  assign unused_wdata = ^c0_wdata_i;

  // Qualification. Reset gates everything so no control output escapes while clr is high.
  logic can_take, id_ok;
  logic q_dtlb, q_ov, q_itlb, q_unimpl, q_sys, q_int, take, eret_go;

  assign can_take = (state_q == StIdle) & ~exl_q & ~clr_i;
  assign id_ok    = can_take & ~stall_id_i;
  assign q_dtlb   = can_take & exc_req_i[4] & en_q[5];
  assign q_ov     = can_take & exc_req_i[3] & en_q[3];
  assign q_itlb   = id_ok & exc_req_i[2] & en_q[4];
  assign q_unimpl = id_ok & exc_req_i[1] & en_q[2];
  assign q_sys    = id_ok & exc_req_i[0] & en_q[1];
  assign q_int    = id_ok & en_q[0] & (|(ip_q & im_q));
  assign take     = q_dtlb | q_ov | q_itlb | q_unimpl | q_sys | q_int;
  // eret does not depend on EXL, only on the FSM being idle and no exception winning.
  assign eret_go  = (state_q == StIdle) & ~clr_i & eret_i & ~take;

  // Priority select of exccode / EPC / BD. Older pipeline stages win.
  logic [4:0]      sel_code;
  logic            sel_bd;
  logic [XLEN-1:0] sel_epc;

  always_comb begin
    sel_code = 5'd0;
    sel_bd   = isbr_d_i;
    sel_epc  = isbr_d_i ? pc_d_i : pc_f_i;
    if (q_dtlb) begin
      sel_code = 5'd5;
      sel_bd   = isbr_w_i;
      sel_epc  = isbr_w_i ? pc_w_i : pc_m_i;
    end else if (q_ov) begin
      sel_code = 5'd3;
      sel_bd   = isbr_m_i;
      sel_epc  = isbr_m_i ? pc_m_i : pc_e_i;
    end else if (q_itlb) begin
      sel_code = 5'd4;
    end else if (q_unimpl) begin
      sel_code = 5'd2;
    end else if (q_sys) begin
      sel_code = 5'd1;
    end
  end

  // FSM next state and control outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    selpc_o     = 2'b00;
    cancel_o    = 1'b0;
    exc_taken_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          exc_taken_o = 1'b1;
          selpc_o     = 2'b10;
          cancel_o    = 1'b1;
          state_d     = StTake;
        end else if (eret_go) begin
          selpc_o = 2'b01;
        end
      end
      StTake: begin
        // TAKE is the first of the FLUSH_CYC post-take cancel cycles.
        cancel_o = 1'b1;
        if (FLUSH_CYC == 1) begin
          state_d = StIdle;
        end else begin
          state_d = StFlush;
          cnt_d   = CntW'(1);
        end
      end
      StFlush: begin
        cancel_o = 1'b1;
        if (cnt_q == CntW'(FLUSH_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Register next-state: mtc0 first, then eret, then a take overrides EXL/Cause/EPC.
  always_comb begin
    en_d   = en_q;
    exl_d  = exl_q;
    im_d   = im_q;
    code_d = code_q;
    bd_d   = bd_q;
    epc_d  = epc_q;
    ip_d   = irq_i;
    if (wc0_i) begin
      case (c0_waddr_i)
        5'd12: begin
          en_d  = c0_wdata_i[5:0];
          exl_d = c0_wdata_i[6];
          im_d  = c0_wdata_i[8 +: NIRQ];
        end
        5'd13: begin
          bd_d   = c0_wdata_i[XLEN-1];
          code_d = c0_wdata_i[6:2];
        end
        5'd14: epc_d = c0_wdata_i;
        default: ;
      endcase
    end
    if (eret_go) begin
      exl_d = 1'b0;
    end
    if (take) begin
      exl_d  = 1'b1;
      code_d = sel_code;
      bd_d   = sel_bd;
      epc_d  = sel_epc;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      en_q    <= '0;
      exl_q   <= 1'b0;
      im_q    <= '0;
      code_q  <= '0;
      bd_q    <= 1'b0;
      ip_q    <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
    end
  end

  // Register views and mfc0 read mux.
  always_comb begin
    sta_o              = '0;
    sta_o[5:0]         = en_q;
    sta_o[6]           = exl_q;
    sta_o[8 +: NIRQ]   = im_q;
    cause_o            = '0;
    cause_o[6:2]       = code_q;
    cause_o[8 +: NIRQ] = ip_q;
    cause_o[XLEN-1]    = bd_q;
    epc_o              = epc_q;
  end

  always_comb begin
    c0_rdata_o = '0;
    case (c0_raddr_i)
      5'd12:   c0_rdata_o = sta_o;
      5'd13:   c0_rdata_o = cause_o;
      5'd14:   c0_rdata_o = epc_o;
      default: c0_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [5:0]  irq;
  logic [4:0]  exc_req;
  logic        stall_id, isbr_d, isbr_m, isbr_w;
  logic [31:0] pc_f, pc_d, pc_e, pc_m, pc_w;
  logic        eret, wc0;
  logic [4:0]  c0_waddr, c0_raddr;
  logic [31:0] c0_wdata, c0_rdata, sta, cause, epc;
  logic [1:0]  selpc;
  logic        cancel, exc_taken;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.NIRQ(6), .XLEN(32), .FLUSH_CYC(2)) dut (
    .clk_i(clk), .clr_i(clr), .irq_i(irq), .exc_req_i(exc_req), .stall_id_i(stall_id),
    .isbr_d_i(isbr_d), .isbr_m_i(isbr_m), .isbr_w_i(isbr_w),
    .pc_f_i(pc_f), .pc_d_i(pc_d), .pc_e_i(pc_e), .pc_m_i(pc_m), .pc_w_i(pc_w),
    .eret_i(eret), .wc0_i(wc0), .c0_waddr_i(c0_waddr), .c0_raddr_i(c0_raddr),
    .c0_wdata_i(c0_wdata), .c0_rdata_o(c0_rdata), .sta_o(sta), .cause_o(cause),
    .epc_o(epc), .selpc_o(selpc), .cancel_o(cancel), .exc_taken_o(exc_taken)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expectations pushed when stimulus is driven, popped at sample time.
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic push(input string n, input logic [31:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic chk(input logic [31:0] act);
    sb_t s;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h, no expectation queued", act);
      return;
    end
    s = sb_q.pop_front();
    if (act !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", s.name, act, s.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq = '0; exc_req = '0; stall_id = 1'b0;
    isbr_d = 1'b0; isbr_m = 1'b0; isbr_w = 1'b0;
    pc_f = 32'h1000; pc_d = 32'h2000; pc_e = 32'h3000; pc_m = 32'h4000; pc_w = 32'h5000;
    eret = 1'b0; wc0 = 1'b0; c0_waddr = '0; c0_raddr = '0; c0_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wr_c0(input logic [4:0] a, input logic [31:0] d);
    wc0 = 1'b1; c0_waddr = a; c0_wdata = d;
    tick();
    wc0 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] sta;
    logic [4:0]  req;
    logic        stall, bd_d, bd_m, bd_w;
    logic [5:0]  irq;
    logic        taken;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];
  vec_t v;
  logic [31:0] exp_cause;

  initial begin
    // sta, req, stall, isbr_d, isbr_m, isbr_w, irq, taken, code, epc, bd
    vecs[0]  = '{32'h03F, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 5'd4, 32'h2000, 1'b1};
    vecs[1]  = '{32'h03F, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd5, 32'h4000, 1'b0};
    vecs[2]  = '{32'h03F, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 1'b1, 5'd5, 32'h5000, 1'b1};
    vecs[3]  = '{32'h03F, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 5'd3, 32'h4000, 1'b1};
    vecs[4]  = '{32'h03F, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd3, 32'h3000, 1'b0};
    vecs[5]  = '{32'h037, 5'b01001, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd1, 32'h1000, 1'b0};
    vecs[6]  = '{32'h03F, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd2, 32'h1000, 1'b0};
    vecs[7]  = '{32'h03F, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[8]  = '{32'h03F, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd3, 32'h3000, 1'b0};
    vecs[9]  = '{32'h13F, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b1, 5'd0, 32'h1000, 1'b0};
    vecs[10] = '{32'h13E, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[11] = '{32'h03F, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[12] = '{32'h000, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[13] = '{32'h07F, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[14] = '{32'h03F, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 5'd5, 32'h4000, 1'b0};
    vecs[15] = '{32'h23F, 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0, 6'h02, 1'b1, 5'd1, 32'h2000, 1'b1};
    vecs[16] = '{32'h01F, 5'b10100, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 5'd4, 32'h1000, 1'b0};

    // Reset state
    idle_inputs();
    clr = 1'b1;
    tick();
    tick();
    push("rst_sta", 32'h0);   chk(sta);
    push("rst_cause", 32'h0); chk(cause);
    push("rst_epc", 32'h0);   chk(epc);
    push("rst_selpc", 32'h0); chk(32'(selpc));
    push("rst_cancel", 32'h0); chk(32'(cancel));
    push("rst_taken", 32'h0); chk(32'(exc_taken));
    clr = 1'b0;

    // Table-driven qualification / priority / EPC selection
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      do_reset();
      irq = v.irq;
      wr_c0(5'd12, v.sta);
      exc_req = v.req; stall_id = v.stall;
      isbr_d = v.bd_d; isbr_m = v.bd_m; isbr_w = v.bd_w;
      push($sformatf("v%0d_taken", i), 32'(v.taken));
      push($sformatf("v%0d_selpc", i), v.taken ? 32'h2 : 32'h0);
      push($sformatf("v%0d_cancel", i), 32'(v.taken));
      @(negedge clk);
      chk(32'(exc_taken)); chk(32'(selpc)); chk(32'(cancel));
      exp_cause = 32'(v.irq) << 8;
      if (v.taken) exp_cause = exp_cause | (32'(v.bd) << 31) | (32'(v.code) << 2);
      push($sformatf("v%0d_sta", i), v.taken ? (v.sta | 32'h40) : v.sta);
      push($sformatf("v%0d_cause", i), exp_cause);
      push($sformatf("v%0d_epc", i), v.taken ? v.epc : 32'h0);
      tick();
      chk(sta); chk(cause); chk(epc);
      idle_inputs();
    end

    // itlb in branch delay slot, cancel duration, then EXL blocking and eret
    do_reset();
    wr_c0(5'd12, 32'h3F);
    pc_d = 32'h100; isbr_d = 1'b1; exc_req = 5'b00100;
    push("t1_taken", 32'h1); push("t1_selpc", 32'h2); push("t1_cancel0", 32'h1);
    @(negedge clk); chk(32'(exc_taken)); chk(32'(selpc)); chk(32'(cancel));
    tick();
    push("t1_cancel1", 32'h1); push("t1_pulse", 32'h0); push("t1_selpc1", 32'h0);
    push("t1_epc", 32'h100); push("t1_cause", 32'h8000_0010); push("t1_sta", 32'h7F);
    chk(32'(cancel)); chk(32'(exc_taken)); chk(32'(selpc)); chk(epc); chk(cause); chk(sta);
    tick();
    push("t1_cancel2", 32'h1); push("t1_pulse2", 32'h0);
    chk(32'(cancel)); chk(32'(exc_taken));
    tick();
    push("t1_cancel3", 32'h0); push("t4_exl_blk", 32'h0);
    chk(32'(cancel)); chk(32'(exc_taken));
    eret = 1'b1;
    push("t4_eret_selpc", 32'h1); push("t4_eret_taken", 32'h0);
    @(negedge clk); chk(32'(selpc)); chk(32'(exc_taken));
    tick();
    eret = 1'b0;
    push("t4_sta", 32'h3F); push("t4_retake", 32'h1); push("t4_retake_selpc", 32'h2);
    chk(sta); chk(32'(exc_taken)); chk(32'(selpc));
    tick();
    idle_inputs();

    // Interrupt held off while ID is stalled
    do_reset();
    irq = 6'h01;
    wr_c0(5'd12, 32'h13F);
    stall_id = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push($sformatf("t3_stall%0d", c), 32'h0);
      @(negedge clk); chk(32'(exc_taken));
      tick();
    end
    stall_id = 1'b0;
    push("t3_take", 32'h1);
    @(negedge clk); chk(32'(exc_taken));
    tick();
    push("t3_cause", 32'h100); push("t3_epc", 32'h1000);
    chk(cause); chk(epc);
    idle_inputs();

    // mtc0 EPC colliding with a sys take: take wins
    do_reset();
    wr_c0(5'd12, 32'h3F);
    pc_f = 32'h40; exc_req = 5'b00001;
    wc0 = 1'b1; c0_waddr = 5'd14; c0_wdata = 32'hDEAD; c0_raddr = 5'd14;
    push("t5_taken", 32'h1); push("t5_rd_old", 32'h0);
    @(negedge clk); chk(32'(exc_taken)); chk(c0_rdata);
    tick();
    wc0 = 1'b0; exc_req = '0;
    push("t5_epc", 32'h40); push("t5_rd", 32'h40);
    chk(epc); chk(c0_rdata);
    idle_inputs();

    // mtc0 Status colliding with a take: EXL from take, other bits from mtc0
    do_reset();
    wr_c0(5'd12, 32'h3F);
    exc_req = 5'b00001;
    wc0 = 1'b1; c0_waddr = 5'd12; c0_wdata = 32'h0F;
    tick();
    wc0 = 1'b0; exc_req = '0;
    push("sta_coll", 32'h4F); push("sta_coll_cause", 32'h04);
    chk(sta); chk(cause);
    idle_inputs();

    // eret coinciding with a qualified exception: exception wins
    do_reset();
    wr_c0(5'd12, 32'h3F);
    exc_req = 5'b00001; eret = 1'b1;
    push("eret_lose_selpc", 32'h2);
    @(negedge clk); chk(32'(selpc));
    tick();
    push("eret_lose_sta", 32'h7F);
    chk(sta);
    idle_inputs();

    // mtc0 Cause: only BD/exccode writable; IP follows irq; mfc0 decode
    do_reset();
    irq = 6'b100000;
    wr_c0(5'd13, 32'hFFFF_FFFF);
    c0_raddr = 5'd13;
    push("cause_wr", 32'h8000_207C); push("cause_rd", 32'h8000_207C);
    #1; chk(cause); chk(c0_rdata);
    c0_raddr = 5'd0;
    push("rd_other", 32'h0);
    #1; chk(c0_rdata);
    idle_inputs();

    // Reset asserted during FLUSH aborts at once
    do_reset();
    wr_c0(5'd12, 32'h3F);
    exc_req = 5'b00001;
    tick();
    exc_req = '0;
    tick();
    push("t6_flush_cancel", 32'h1);
    chk(32'(cancel));
    clr = 1'b1;
    #1;
    push("t6_cancel", 32'h0); push("t6_selpc", 32'h0);
    push("t6_sta", 32'h0); push("t6_cause", 32'h0); push("t6_epc", 32'h0);
    chk(32'(cancel)); chk(32'(selpc)); chk(sta); chk(cause); chk(epc);
    tick();
    clr = 1'b0;

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
